// File: rtl/gelu_lut_loader.sv
// Streams a header byte plus 256 LUT bytes into one of four GELU LUT BRAM layers.
// Define GELU_LOADER_CHKSUM_EN to require a trailing XOR checksum byte per frame.
module gelu_lut_loader #(
    parameter logic [5:0]  MAGIC       = 6'h2A,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] s_data_i,
    input  logic       s_valid_i,
    output logic       s_ready_o,
    output logic       lut_we_o,
    output logic [9:0] lut_waddr_o,
    output logic [7:0] lut_wdata_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [3:0] layer_ok_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

`ifdef GELU_LOADER_CHKSUM_EN
    typedef enum logic [1:0] {StIdle = 2'd0, StData = 2'd1, StDone = 2'd2, StChk = 2'd3} state_e;
`else
    typedef enum logic [1:0] {StIdle = 2'd0, StData = 2'd1, StDone = 2'd2} state_e;
`endif

    state_e          state, state_next;
    logic [1:0]      layer, layer_next;
    logic [7:0]      index, index_next;
    logic [CntW-1:0] idle_cnt, idle_cnt_next;
    logic            we_next;
    logic [9:0]      waddr_next;
    logic [7:0]      wdata_next;
    logic            err_next;
    logic [3:0]      layer_ok_next;
    logic            xfer;
    logic            in_frame;
`ifdef GELU_LOADER_CHKSUM_EN
    logic [7:0]      xacc, xacc_next;
`endif

    // Ready is gated by reset so nothing is accepted while rst_ni is held low.
    assign s_ready_o = rst_ni && (state != StDone);
    assign xfer      = s_valid_i && s_ready_o;
    assign busy_o    = (state != StIdle);
    assign done_o    = (state == StDone);
    assign in_frame  = (state != StIdle) && (state != StDone);

    always_comb begin
        state_next    = state;
        layer_next    = layer;
        index_next    = index;
        idle_cnt_next = idle_cnt;
        we_next       = 1'b0;
        waddr_next    = lut_waddr_o;
        wdata_next    = lut_wdata_o;
        err_next      = 1'b0;
        layer_ok_next = layer_ok_o;
`ifdef GELU_LOADER_CHKSUM_EN
        xacc_next     = xacc;
`endif
        case (state)
            StIdle: begin
                if (xfer) begin
                    if (s_data_i[7:2] == MAGIC) begin
                        layer_next                   = s_data_i[1:0];
                        layer_ok_next[s_data_i[1:0]] = 1'b0;
                        index_next                   = 8'd0;
                        state_next                   = StData;
`ifdef GELU_LOADER_CHKSUM_EN
                        xacc_next                    = 8'd0;
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            StData: begin
                if (xfer) begin
                    we_next    = 1'b1;
                    waddr_next = {layer, index};
                    wdata_next = s_data_i;
                    index_next = index + 8'd1;
`ifdef GELU_LOADER_CHKSUM_EN
                    xacc_next  = xacc ^ s_data_i;
                    if (index == 8'hFF) state_next = StChk;
`else
                    if (index == 8'hFF) begin
                        state_next           = StDone;
                        layer_ok_next[layer] = 1'b1;
                    end
`endif
                end
            end
`ifdef GELU_LOADER_CHKSUM_EN
            StChk: begin
                if (xfer) begin
                    state_next = StDone;
                    if (s_data_i == xacc) layer_ok_next[layer] = 1'b1;
                    else                  err_next             = 1'b1;
                end
            end
`endif
            StDone:  state_next = StIdle;
            default: state_next = StIdle;
        endcase

        // Idle watchdog: any transfer clears it; a stalled frame is abandoned.
        if (xfer) begin
            idle_cnt_next = '0;
        end else if (in_frame) begin
            if (idle_cnt == CntW'(TIMEOUT_CYC - 1)) begin
                err_next      = 1'b1;
                state_next    = StIdle;
                idle_cnt_next = '0;
            end else begin
                idle_cnt_next = idle_cnt + CntW'(1);
            end
        end else begin
            idle_cnt_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= StIdle;
            layer       <= 2'd0;
            index       <= 8'd0;
            idle_cnt    <= '0;
            lut_we_o    <= 1'b0;
            lut_waddr_o <= 10'd0;
            lut_wdata_o <= 8'd0;
            err_o       <= 1'b0;
            layer_ok_o  <= 4'b0000;
`ifdef GELU_LOADER_CHKSUM_EN
            xacc        <= 8'd0;
`endif
        end else begin
            state       <= state_next;
            layer       <= layer_next;
            index       <= index_next;
            idle_cnt    <= idle_cnt_next;
            lut_we_o    <= we_next;
            lut_waddr_o <= waddr_next;
            lut_wdata_o <= wdata_next;
            err_o       <= err_next;
            layer_ok_o  <= layer_ok_next;
`ifdef GELU_LOADER_CHKSUM_EN
            xacc        <= xacc_next;
`endif
        end
    end

endmodule

// File: tb/tb_gelu_lut_loader.sv
// Directed bench for gelu_lut_loader: expected LUT writes are queued as bytes are
// driven and popped as writes appear; honours GELU_LOADER_CHKSUM_EN like the design.
module tb_gelu_lut_loader;

    localparam logic [5:0] MAGIC = 6'h2A;
    localparam int         TO    = 1024;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready_o, lut_we_o, busy_o, done_o, err_o;
    logic [9:0] lut_waddr_o;
    logic [7:0] lut_wdata_o;
    logic [3:0] layer_ok_o;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
    logic [3:0] ok_at_done = 4'd0;
    logic       err_at_done = 1'b0;
    logic [17:0] exp_q[$];

    gelu_lut_loader #(.MAGIC(MAGIC), .TIMEOUT_CYC(TO)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .s_data_i    (s_data),
        .s_valid_i   (s_valid),
        .s_ready_o   (s_ready_o),
        .lut_we_o    (lut_we_o),
        .lut_waddr_o (lut_waddr_o),
        .lut_wdata_o (lut_wdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .layer_ok_o  (layer_ok_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (lut_we_o) begin
                wr_cnt++;
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    logic [17:0] e;
                    e = exp_q.pop_front();
                    check("write_addr", 32'(lut_waddr_o), 32'(e[17:8]));
                    check("write_data", 32'(lut_wdata_o), 32'(e[7:0]));
                end
            end
            if (done_o) begin
                done_cnt++;
                ok_at_done  = layer_ok_o;
                err_at_done = err_o;
                check("ready_low_in_done", 32'(s_ready_o), 32'd0);
            end
            if (err_o) err_cnt++;
        end
    end

    // Called at a negedge; returns at the negedge after the byte transfers.
    task automatic send(input logic [7:0] b, input bit wr, input logic [9:0] a, input int gap);
        int guard = 0;
        repeat (gap) @(negedge clk);
        s_data  = b;
        s_valid = 1'b1;
        while (!s_ready_o && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("ready_wait_timeout", 32'(guard), 32'd0);
        if (wr) exp_q.push_back({a, b});
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic frame(input logic [1:0] ly, input logic [7:0] xv, input int maxgap,
                         input int nbytes, input bit corrupt);
        logic [7:0] x = 8'd0;
        logic [7:0] d;
        send({MAGIC, ly}, 1'b0, 10'd0, 0);
        for (int i = 0; i < nbytes; i++) begin
            d = 8'(i) ^ xv;
            x ^= d;
            send(d, 1'b1, {ly, 8'(i)}, int'($urandom_range(maxgap, 0)));
        end
`ifdef GELU_LOADER_CHKSUM_EN
        if (nbytes == 256) send(corrupt ? ~x : x, 1'b0, 10'd0, 0);
`else
        if (corrupt) x = ~x;
`endif
    endtask

    initial begin
        int w0, d0, e0, n;

        // Reset state
        #3;
        check("rst_ready", 32'(s_ready_o), 32'd0);
        check("rst_we", 32'(lut_we_o), 32'd0);
        check("rst_waddr", 32'(lut_waddr_o), 32'd0);
        check("rst_wdata", 32'(lut_wdata_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done_err", 32'({done_o, err_o}), 32'd0);
        check("rst_layer_ok", 32'(layer_ok_o), 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(s_ready_o), 32'd1);

        // Layer 1 full frame, data == index
        w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
        frame(2'd1, 8'h00, 0, 256, 1'b0);
        repeat (2) @(negedge clk);
        check("l1_writes", 32'(wr_cnt - w0), 32'd256);
        check("l1_done", 32'(done_cnt - d0), 32'd1);
        check("l1_no_err", 32'(err_cnt - e0), 32'd0);
        check("l1_ok_in_done", 32'(ok_at_done), 32'b0010);
        check("l1_layer_ok", 32'(layer_ok_o), 32'b0010);
        check("l1_idle", 32'(busy_o), 32'd0);

        // Bad magic header, then layer 0 loads normally
        w0 = wr_cnt; e0 = err_cnt;
        send(8'h55, 1'b0, 10'd0, 0);
        check("bad_hdr_busy", 32'(busy_o), 32'd0);
        repeat (2) @(negedge clk);
        check("bad_hdr_err", 32'(err_cnt - e0), 32'd1);
        check("bad_hdr_writes", 32'(wr_cnt - w0), 32'd0);
        check("bad_hdr_busy2", 32'(busy_o), 32'd0);
        d0 = done_cnt;
        frame(2'd0, 8'hFF, 0, 256, 1'b0);
        repeat (2) @(negedge clk);
        check("l0_done", 32'(done_cnt - d0), 32'd1);
        check("l0_layer_ok", 32'(layer_ok_o), 32'b0011);

        // Timeout after 100 bytes on layer 3
        w0 = wr_cnt; e0 = err_cnt;
        frame(2'd3, 8'h5A, 0, 100, 1'b0);
        n = 0;
        for (int k = 1; k <= TO + 20; k++) begin
            @(negedge clk);
            n = k;
            if (err_o) break;
        end
        check("to_latency", 32'(n), 32'(TO));
        @(negedge clk);
        check("to_writes", 32'(wr_cnt - w0), 32'd100);
        check("to_err", 32'(err_cnt - e0), 32'd1);
        check("to_idle", 32'(busy_o), 32'd0);
        check("to_layer_ok", 32'(layer_ok_o), 32'b0011);

        // Layer 2 frame with random valid gaps
        d0 = done_cnt;
        frame(2'd2, 8'h3C, 6, 256, 1'b0);
        repeat (2) @(negedge clk);
        check("gap_done", 32'(done_cnt - d0), 32'd1);
        check("gap_layer_ok", 32'(layer_ok_o), 32'b0111);

        // Asynchronous reset at data byte 50 of a layer 1 frame
        frame(2'd1, 8'h11, 0, 50, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(s_ready_o), 32'd0);
        check("mid_rst_we", 32'(lut_we_o), 32'd0);
        check("mid_rst_addr_data", 32'({lut_waddr_o, lut_wdata_o}), 32'd0);
        check("mid_rst_busy", 32'({busy_o, done_o, err_o}), 32'd0);
        check("mid_rst_layer_ok", 32'(layer_ok_o), 32'd0);
        check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        d0 = done_cnt;
        frame(2'd1, 8'hA5, 0, 256, 1'b0);
        repeat (2) @(negedge clk);
        check("post_rst_done", 32'(done_cnt - d0), 32'd1);
        check("post_rst_layer_ok", 32'(layer_ok_o), 32'b0010);

`ifdef GELU_LOADER_CHKSUM_EN
        // Corrupted checksum on layer 3, then correct checksum on layer 0
        d0 = done_cnt; e0 = err_cnt;
        frame(2'd3, 8'h77, 0, 256, 1'b1);
        repeat (2) @(negedge clk);
        check("bad_chk_done", 32'(done_cnt - d0), 32'd1);
        check("bad_chk_err", 32'(err_cnt - e0), 32'd1);
        check("bad_chk_err_in_done", 32'(err_at_done), 32'd1);
        check("bad_chk_layer_ok", 32'(layer_ok_o), 32'b0010);
        d0 = done_cnt; e0 = err_cnt;
        frame(2'd0, 8'h0F, 2, 256, 1'b0);
        repeat (2) @(negedge clk);
        check("good_chk_done", 32'(done_cnt - d0), 32'd1);
        check("good_chk_no_err", 32'(err_cnt - e0), 32'd0);
        check("good_chk_layer_ok", 32'(layer_ok_o), 32'b0011);
`endif

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
